// File: rtl/exec_pkg.sv
// Shared definitions for the execution unit: opcodes, instruction field
// positions, controller states and flag bit positions.
package exec_pkg;

   localparam logic [4:0] OP_MOVSGPR = 5'd0;
   localparam logic [4:0] OP_MOV     = 5'd1;
   localparam logic [4:0] OP_ADD     = 5'd2;
   localparam logic [4:0] OP_SUB     = 5'd3;
   localparam logic [4:0] OP_MUL     = 5'd4;
   localparam logic [4:0] OP_OR      = 5'd5;
   localparam logic [4:0] OP_AND     = 5'd6;
   localparam logic [4:0] OP_XOR     = 5'd7;
   localparam logic [4:0] OP_XNOR    = 5'd8;
   localparam logic [4:0] OP_NAND    = 5'd9;
   localparam logic [4:0] OP_NOR     = 5'd10;
   localparam logic [4:0] OP_NOT     = 5'd11;

   localparam int OPER_LSB     = 27;
   localparam int OPER_W       = 5;
   localparam int RDST_LSB     = 22;
   localparam int RSRC1_LSB    = 17;
   localparam int IMM_MODE_BIT = 16;
   localparam int RSRC2_LSB    = 11;
   localparam int REG_FIELD_W  = 5;

   localparam int FLAG_C = 0;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 2;
   localparam int FLAG_S = 3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MUL      = 2'd1,
      ST_DONE_MUL = 2'd2
   } state_e;

   function automatic logic op_is_legal(input logic [4:0] op);
      return (op <= OP_NOT);
   endfunction

endpackage

// File: rtl/exec_unit_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W cycles
// per multiply, with start/busy/done handshake.
module mul_seq #(
   parameter int DATA_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [DATA_W-1:0]     a_i,
   input  logic [DATA_W-1:0]     b_i,
   output logic                  busy_o,
   output logic                  last_o,
   output logic                  done_o,
   output logic [2*DATA_W-1:0]   product_o
);

   localparam int CW = $clog2(DATA_W) + 1;

   logic [2*DATA_W-1:0] mcand_q;
   logic [2*DATA_W-1:0] prod_q;
   logic [2*DATA_W-1:0] prod_d;
   logic [DATA_W-1:0]   mplier_q;
   logic [CW-1:0]       cnt_q;
   logic                busy_q;
   logic                done_q;
   logic                last_s;

   // last_s flags the step that completes the product, so the caller can
   // change state on the same edge the final partial product lands.
   assign last_s = busy_q && (cnt_q == CW'(DATA_W - 1));

   // Partial-product accumulation for the current multiplier bit.
   always_comb begin
      prod_d = prod_q;
      if (mplier_q[0]) begin
         prod_d = prod_q + mcand_q;
      end else begin
         prod_d = prod_q;
      end
   end

   // Operand capture on start, then one shift-add step per cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_i && !busy_q) begin
            mcand_q  <= {{DATA_W{1'b0}}, a_i};
            mplier_q <= b_i;
            prod_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
         end else if (busy_q) begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (last_s) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign busy_o    = busy_q;
   assign last_o    = last_s;
   assign done_o    = done_q;
   assign product_o = prod_q;

endmodule

// File: rtl/exec_unit.sv
// Single-issue execution unit: GPR file, ALU with flags, special register for
// the upper half of products, and a sequential multiplier.
module exec_unit
   import exec_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREG   = 32,
   parameter int IMM_W  = 16
) (
   input  logic              clk,
   input  logic              sys_rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [31:0]       instr,
   output logic              done,
   output logic              illegal,
   output logic [3:0]        flags,
   output logic [DATA_W-1:0] sgpr,
   input  logic [4:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

   logic [DATA_W-1:0]   gpr_q [NREG];
   logic [DATA_W-1:0]   sgpr_q;
   logic [3:0]          flags_q;
   logic                done_q;
   logic                illegal_q;
   logic [AW-1:0]       mul_rdst_q;
   state_e              state_q;
   state_e              state_d;

   logic [4:0]          oper_s;
   logic [AW-1:0]       rdst_s;
   logic [AW-1:0]       rsrc1_s;
   logic [AW-1:0]       rsrc2_s;
   logic                imm_mode_s;
   logic [DATA_W-1:0]   imm_ext_s;
   logic [DATA_W-1:0]   op_a_s;
   logic [DATA_W-1:0]   op_b_s;
   logic [DATA_W:0]     sum_s;
   logic [DATA_W:0]     diff_s;
   logic [DATA_W-1:0]   alu_res_s;
   logic                alu_v_s;
   logic                alu_c_s;
   logic [3:0]          alu_flags_s;
   logic [3:0]          mul_flags_s;
   logic                op_legal_s;
   logic                accept_s;
   logic                mul_start_s;
   logic                mul_busy_s;
   logic                mul_last_s;
   logic                mul_done_s;
   logic [2*DATA_W-1:0] mul_prod_s;

   assign oper_s     = instr[OPER_LSB +: OPER_W];
   assign rdst_s     = instr[RDST_LSB +: AW];
   assign rsrc1_s    = instr[RSRC1_LSB +: AW];
   assign rsrc2_s    = instr[RSRC2_LSB +: AW];
   assign imm_mode_s = instr[IMM_MODE_BIT];

   generate
      if (IMM_W >= DATA_W) begin : g_imm_trunc
         assign imm_ext_s = instr[DATA_W-1:0];
      end else begin : g_imm_zext
         assign imm_ext_s = {{(DATA_W-IMM_W){1'b0}}, instr[IMM_W-1:0]};
      end
   endgenerate

   // Sources read the pre-edge register state, so dependent ops need no stall.
   assign op_a_s      = gpr_q[rsrc1_s];
   assign op_b_s      = imm_mode_s ? imm_ext_s : gpr_q[rsrc2_s];
   assign sum_s       = {1'b0, op_a_s} + {1'b0, op_b_s};
   assign diff_s      = {1'b0, op_a_s} - {1'b0, op_b_s};
   assign op_legal_s  = op_is_legal(oper_s);
   assign instr_ready = sys_rst_n && (state_q == ST_IDLE);
   assign accept_s    = instr_valid && instr_ready;
   assign mul_start_s = accept_s && (oper_s == OP_MUL);

   // Single-cycle ALU result and add/sub carry/overflow.
   always_comb begin
      alu_res_s = '0;
      alu_v_s   = 1'b0;
      alu_c_s   = 1'b0;
      case (oper_s)
         OP_MOVSGPR: alu_res_s = sgpr_q;
         OP_MOV:     alu_res_s = op_b_s;
         OP_ADD: begin
            alu_res_s = sum_s[DATA_W-1:0];
            alu_c_s   = sum_s[DATA_W];
            alu_v_s   = (op_a_s[DATA_W-1] == op_b_s[DATA_W-1]) &&
                        (sum_s[DATA_W-1] != op_a_s[DATA_W-1]);
         end
         OP_SUB: begin
            alu_res_s = diff_s[DATA_W-1:0];
            alu_c_s   = diff_s[DATA_W];
            alu_v_s   = (op_a_s[DATA_W-1] != op_b_s[DATA_W-1]) &&
                        (diff_s[DATA_W-1] != op_a_s[DATA_W-1]);
         end
         OP_OR:      alu_res_s = op_a_s | op_b_s;
         OP_AND:     alu_res_s = op_a_s & op_b_s;
         OP_XOR:     alu_res_s = op_a_s ^ op_b_s;
         OP_XNOR:    alu_res_s = ~(op_a_s ^ op_b_s);
         OP_NAND:    alu_res_s = ~(op_a_s & op_b_s);
         OP_NOR:     alu_res_s = ~(op_a_s | op_b_s);
         OP_NOT:     alu_res_s = imm_mode_s ? ~imm_ext_s : ~op_a_s;
         default:    alu_res_s = '0;
      endcase
   end

   // Flag vectors for the ALU path and the multiply path.
   always_comb begin
      alu_flags_s         = 4'b0000;
      alu_flags_s[FLAG_S] = alu_res_s[DATA_W-1];
      alu_flags_s[FLAG_Z] = (alu_res_s == '0);
      alu_flags_s[FLAG_V] = alu_v_s;
      alu_flags_s[FLAG_C] = alu_c_s;
      mul_flags_s         = 4'b0000;
      mul_flags_s[FLAG_S] = mul_prod_s[2*DATA_W-1];
      mul_flags_s[FLAG_Z] = (mul_prod_s == '0);
   end

   mul_seq #(
      .DATA_W (DATA_W)
   ) u_mul_seq (
      .clk       (clk),
      .rst_n     (sys_rst_n),
      .start_i   (mul_start_s),
      .a_i       (op_a_s),
      .b_i       (op_b_s),
      .busy_o    (mul_busy_s),
      .last_o    (mul_last_s),
      .done_o    (mul_done_s),
      .product_o (mul_prod_s)
   );

   // Controller state register.
   always_ff @(posedge clk) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Controller next state; a multiplier that is no longer busy drops back to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (mul_start_s) begin
               state_d = ST_MUL;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL: begin
            if (mul_last_s) begin
               state_d = ST_DONE_MUL;
            end else if (mul_busy_s) begin
               state_d = ST_MUL;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DONE_MUL: state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Architectural state update and retirement pulses.
   always_ff @(posedge clk) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            gpr_q[i] <= '0;
         end
         sgpr_q     <= '0;
         flags_q    <= 4'b0000;
         done_q     <= 1'b0;
         illegal_q  <= 1'b0;
         mul_rdst_q <= '0;
      end else begin
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         if (accept_s) begin
            if (!op_legal_s) begin
               done_q    <= 1'b1;
               illegal_q <= 1'b1;
            end else if (oper_s == OP_MUL) begin
               mul_rdst_q <= rdst_s;
            end else begin
               gpr_q[rdst_s] <= alu_res_s;
               flags_q       <= alu_flags_s;
               done_q        <= 1'b1;
            end
         end else if ((state_q == ST_DONE_MUL) && mul_done_s) begin
            gpr_q[mul_rdst_q] <= mul_prod_s[DATA_W-1:0];
            sgpr_q            <= mul_prod_s[2*DATA_W-1:DATA_W];
            flags_q           <= mul_flags_s;
            done_q            <= 1'b1;
         end
      end
   end

   assign done     = done_q;
   assign illegal  = illegal_q;
   assign flags    = flags_q;
   assign sgpr     = sgpr_q;
   assign dbg_data = gpr_q[dbg_addr[AW-1:0]];

endmodule
